// File: rtl/fft_bitrev_buf.sv
// -----------------------------------------------------------------------------
// fft_bitrev_buf
//
// Frame reorder buffer for a radix-2 FFT. A frame of N = 2^AW samples arrives
// in natural order and is written into an external single-port RAM. Once the
// frame is complete, the RAM is read back in bit-reversed address order and
// streamed out through a small 2-entry output FIFO. The input is held off
// while a frame drains, so one RAM port is enough.
//
// Handshake rule (both stream ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. A source holding valid=1 keeps its data
// stable until that transfer; ready may change freely.
//
// Ports
//   clk, rst      : single clock, synchronous active-high reset
//   s_data/s_valid/s_ready : natural-order input stream
//   m_data/m_valid/m_ready : bit-reversed output stream
//   m_last        : final sample of the frame (qualified by m_valid)
//   ram_data/ram_addr/ram_we : RAM write data, address, write enable
//   ram_q         : RAM read data, valid the cycle after the address
//   dbg_state     : FSM state for observation (0 = FILL, 1 = DRAIN)
// -----------------------------------------------------------------------------
module fft_bitrev_buf #(
    parameter int DW = 8,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic          dbg_state
);

    localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state;

    // Write and read sample counters
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    // Set once the final read of the frame has been issued
    logic          rd_done;

    // One read can be in flight: address presented last cycle, data on ram_q now
    logic          in_flight;
    logic          in_flight_last;

    // 2-entry output FIFO
    logic [DW-1:0] fifo_data [2];
    logic          fifo_last [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    fifo_count;

    logic          accept;
    logic          pop;
    logic          rd_issue;
    logic [2:0]    occupancy;
    logic [AW-1:0] rd_addr_rev;

    // -------------------------------------------------------------------------
    // Handshakes. Outputs are forced inactive while rst is high so the reset
    // cycle itself shows no ready/valid, even if the state register has not
    // yet been cleared.
    // -------------------------------------------------------------------------
    assign s_ready = (state == FILL) && !rst;
    assign accept  = s_valid && s_ready;

    assign m_valid = (fifo_count != 2'd0) && !rst;
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = m_valid && fifo_last[rd_ptr];
    assign pop     = m_valid && m_ready;

    assign dbg_state = (state == DRAIN);

    // -------------------------------------------------------------------------
    // Read issue. Count what the FIFO will hold once the in-flight read lands,
    // net of any pop this cycle. Only issue if that leaves room for one more,
    // which guarantees no overflow however m_ready behaves.
    // -------------------------------------------------------------------------
    assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
    assign rd_issue  = (state == DRAIN) && !rd_done && (occupancy < 3'd2) && !rst;

    // Bit i of the read address is bit AW-1-i of the read counter
    always_comb begin
        rd_addr_rev = '0;
        for (int i = 0; i < AW; i++) begin
            rd_addr_rev[i] = rd_cnt[AW-1-i];
        end
    end

    // -------------------------------------------------------------------------
    // RAM port. Writes happen only on accepted input samples; in DRAIN the
    // address carries the bit-reversed read pointer. Outside a write or read
    // the address value is irrelevant.
    // -------------------------------------------------------------------------
    assign ram_we   = accept;
    assign ram_data = s_data;
    assign ram_addr = (state == DRAIN) ? rd_addr_rev : wr_cnt;

    // -------------------------------------------------------------------------
    // FSM, counters and FIFO control
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FILL;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            rd_done        <= 1'b0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            fifo_count     <= 2'd0;
        end else begin
            in_flight      <= rd_issue;
            in_flight_last <= rd_issue && (rd_cnt == LAST_IDX);

            case (state)
                FILL: begin
                    if (accept) begin
                        // Wraps to 0 after the last sample of the frame
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_issue) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST_IDX) begin
                            rd_done <= 1'b1;
                        end
                    end
                    // The last sample is the only thing left in the pipeline
                    // when it is handed off, so the FIFO empties here too.
                    if (pop && m_last) begin
                        state   <= FILL;
                        rd_cnt  <= '0;
                        rd_done <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase

            if (in_flight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, in_flight} - {1'b0, pop};
        end
    end

    // FIFO storage needs no reset: entries are only visible through fifo_count
    always_ff @(posedge clk) begin
        if (in_flight) begin
            fifo_data[wr_ptr] <= ram_q;
            fifo_last[wr_ptr] <= in_flight_last;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_buf
//
// Bench for fft_bitrev_buf with AW=3 (N=8). A behavioural RAM sits on the RAM
// port. The reference model turns each fully written frame into its expected
// output sequence by bit-reversing sample indices arithmetically and pushing
// the samples into exp_q; the monitor pops and compares on every output
// transfer and also checks stall stability, ready behaviour and reset outputs.
// -----------------------------------------------------------------------------
module tb_fft_bitrev_buf;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int N  = 1 << AW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic          dbg_state;

    fft_bitrev_buf #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural registered-address RAM ----------------
    logic [DW-1:0] ram_mem [N];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    int n_tests   = 0;
    int n_fail    = 0;
    int out_cnt   = 0;
    bit in_drain  = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0
    int tcnt      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int bitrev(input int x);
        int r = 0;
        for (int b = 0; b < AW; b++) r = r * 2 + ((x >> b) % 2);
        return r;
    endfunction

    // ---------------- driver ----------------
    // Writes the first n samples of d; a full frame also loads the model.
    task automatic push_frame(input logic [DW-1:0] d [N], input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            bit got = 0;
            int gaps = 0;
            while (gaps < 4 && $urandom_range(0, 99) < gap_pct) begin
                @(negedge clk);
                s_valid = 1'b0;
                #1;
                chk("gap_we", ram_we, 0);
                gaps++;
            end
            for (int t = 0; t < 300 && !got; t++) begin
                @(negedge clk);
                s_valid = 1'b1;
                s_data  = d[i];
                #1;
                if (s_ready) begin
                    chk("accept_not_draining", in_drain, 0);
                    chk("wr_we", ram_we, 1);
                    chk("wr_addr", ram_addr, i);
                    chk("wr_data", ram_data, d[i]);
                    @(posedge clk);
                    #1;
                    got = 1;
                end else begin
                    chk("stalled_we", ram_we, 0);
                end
            end
            chk("accept_timeout", got, 1);
            if (!got) begin
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        if (n == N) begin
            for (int r = 0; r < N; r++) exp_q.push_back(d[bitrev(r)]);
            in_drain = 1;
        end
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(posedge clk);
            if (!in_drain && exp_q.size() == 0) done = 1;
        end
        chk("drain_timeout", done, 1);
        if (!done) begin
            exp_q.delete();
            in_drain = 0;
            out_cnt  = 0;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        in_drain = 0;
        out_cnt  = 0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- monitor / sink ----------------
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    initial begin
        logic [DW-1:0] e;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: begin m_ready = (tcnt % 3 == 0); tcnt++; end
            endcase
            @(negedge clk);
            if (rst) begin
                chk("rst_s_ready", s_ready, 0);
                chk("rst_m_valid", m_valid, 0);
                chk("rst_m_last", m_last, 0);
                chk("rst_ram_we", ram_we, 0);
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, prev_data);
                    chk("stall_last", m_last, prev_last);
                end
                chk("s_ready_phase", s_ready, !in_drain);
                if (in_drain) chk("drain_we", ram_we, 0);
                if (m_valid && m_ready) begin
                    chk("out_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("m_data", m_data, e);
                        chk("m_last", m_last, out_cnt == N - 1);
                        out_cnt++;
                        if (out_cnt == N) begin
                            out_cnt  = 0;
                            in_drain = 0;
                        end
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [DW-1:0] d [N];
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_s_ready", s_ready, 1);
        chk("post_reset_m_valid", m_valid, 0);

        // Continuous fill, always ready: 2-cycle latency then one per cycle
        for (int i = 0; i < N; i++) d[i] = DW'(10 + i);
        ready_mode = 0;
        push_frame(d, N, 0);
        @(negedge clk); chk("lat_cycle0_valid", m_valid, 0);
        @(negedge clk); chk("lat_cycle1_valid", m_valid, 0);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("stream_valid", m_valid, 1);
        end
        wait_drain();
        @(negedge clk);
        chk("refill_s_ready", s_ready, 1);

        // Same frame, ready pattern 1,0,0
        ready_mode = 2;
        tcnt = 0;
        push_frame(d, N, 0);
        wait_drain();

        // Input gaps during fill
        ready_mode = 0;
        push_frame(d, N, 40);
        wait_drain();

        // Back-to-back frames
        push_frame(d, N, 0);
        for (int i = 0; i < N; i++) d[i] = DW'(20 + i);
        push_frame(d, N, 0);
        wait_drain();

        // Reset after the third output sample
        for (int i = 0; i < N; i++) d[i] = DW'(10 + i);
        push_frame(d, N, 0);
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (out_cnt >= 3) break;
        end
        chk("reached_third_output", out_cnt >= 3, 1);
        #1 rst = 1'b1;
        exp_q.delete();
        in_drain = 0;
        out_cnt  = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_s_ready", s_ready, 1);
        for (int i = 0; i < N; i++) d[i] = DW'(30 + i);
        push_frame(d, N, 0);
        wait_drain();

        // Reset in the middle of a fill; the partial frame must never show up
        for (int i = 0; i < N; i++) d[i] = DW'(8'hA0 + i);
        push_frame(d, 5, 0);
        do_reset(2);
        for (int i = 0; i < N; i++) d[i] = DW'($urandom_range(0, 255));
        push_frame(d, N, 20);
        wait_drain();

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            ready_mode = $urandom_range(0, 2);
            for (int i = 0; i < N; i++) d[i] = DW'($urandom_range(0, 255));
            push_frame(d, N, $urandom_range(0, 50));
            if ($urandom_range(0, 3) == 0) begin
                wait_drain();
            end
        end
        wait_drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_buf.md
FFT_BITREV_BUF -- requirements
Module: fft_bitrev_buf

Interface
REQ-001 Parameter DW, default 8, sample width in bits.
REQ-002 Parameter AW, default 11, frame address width; frame length N = 2^AW samples.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 s_data  in  DW  input sample, natural order.
REQ-006 s_valid  in  1  input sample valid.
REQ-007 s_ready  out  1  block accepts an input sample.
REQ-008 m_data  out  DW  output sample, bit-reversed order.
REQ-009 m_valid  out  1  output sample valid.
REQ-010 m_ready  in  1  downstream accepts the output sample.
REQ-011 m_last  out  1  marks the final sample of the frame, qualified by m_valid.
REQ-012 ram_data  out  DW  write data to the external single-port RAM.
REQ-013 ram_addr  out  AW  RAM address.
REQ-014 ram_we  out  1  RAM write enable.
REQ-015 ram_q  in  DW  RAM read data; valid in the cycle after the address is presented (registered-address RAM).

Function
REQ-016 The block SHALL use a two-state FSM: FILL and DRAIN.
REQ-017 In FILL, s_ready SHALL be 1; in DRAIN, s_ready SHALL be 0.
REQ-018 A sample SHALL be accepted when s_valid and s_ready are both 1; only then SHALL ram_we=1, ram_addr=wr_cnt and ram_data=s_data in the same cycle.
REQ-019 wr_cnt (AW bits) SHALL increment per accepted sample; acceptance at wr_cnt=N-1 SHALL wrap wr_cnt to 0 and move the FSM to DRAIN on the next cycle.
REQ-020 Input gaps (s_valid=0) SHALL stall the fill and leave wr_cnt unchanged; ram_we SHALL be 0.
REQ-021 In DRAIN, ram_we SHALL be 0 in every cycle.
REQ-022 In DRAIN, a read SHALL be issued by driving ram_addr = bit-reverse(rd_cnt), where bit i of the address equals bit AW-1-i of rd_cnt; rd_cnt SHALL increment per issued read, from 0 to N-1.
REQ-023 Returned data (ram_q, one cycle after issue) SHALL be written into an internal 2-entry output FIFO that drives m_data/m_valid from its head.
REQ-024 A read SHALL be issued only when (fifo_count + reads_in_flight - pop_this_cycle) < 2, so the FIFO never overflows under any m_ready pattern.
REQ-025 With m_ready held at 1, the block SHALL output one sample per cycle after a 2-cycle initial latency from entering DRAIN.
REQ-026 m_data and m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-027 m_last SHALL be 1 only on the N-th output sample of the frame.
REQ-028 The FSM SHALL return to FILL in the cycle after the m_last handshake, with rd_cnt=0 and the FIFO empty; s_ready SHALL then be 1.
REQ-029 No read SHALL be issued after rd_cnt has issued address bit-reverse(N-1) in the current frame.
REQ-030 ram_addr is don't-care whenever neither a write nor a read is issued.

Reset
REQ-031 While rst=1, the FSM SHALL enter FILL, wr_cnt, rd_cnt and in-flight state SHALL clear, and the FIFO SHALL empty.
REQ-032 While rst=1, outputs SHALL be: s_ready=0, m_valid=0, m_last=0, ram_we=0. On the first cycle after rst deasserts, s_ready SHALL be 1.
REQ-033 Reset asserted mid-FILL or mid-DRAIN SHALL abort the frame; data from the partial frame SHALL never appear on m_data.

Verification (AW=3, N=8)
REQ-034 Write 10..17 continuously, m_ready=1 -> output order 10,14,12,16,11,15,13,17; m_last only with 17; s_ready=0 for the whole output phase.
REQ-035 Fill as in REQ-034 with m_ready toggling 1,0,0,1,... -> same order, no sample lost or duplicated, m_data stable whenever m_ready=0, FIFO occupancy never exceeds 2.
REQ-036 Insert s_valid gaps during fill -> ram_we=0 in each gap cycle; output is identical to REQ-034.
REQ-037 Two back-to-back frames (10..17, then 20..27) -> second frame accepted only after the m_last handshake; outputs 20,24,22,26,21,25,23,27.
REQ-038 rst pulse after the 3rd output sample -> m_valid=0 on the next cycle, then s_ready=1; a fresh frame 30..37 outputs 30,34,32,36,31,35,33,37.
